// File: rtl/bus_arbiter_2_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_2_if
// Brief    : Host, downstream and status signals of the two-host bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_2_if;
  logic [31:0] host0_address;
  logic [31:0] host0_data_write;
  logic [3:0]  host0_write_mask;
  logic        host0_wen;
  logic        host0_ren;
  logic [31:0] host0_data_read;
  logic        host0_ready;

  logic [31:0] host1_address;
  logic [31:0] host1_data_write;
  logic [3:0]  host1_write_mask;
  logic        host1_wen;
  logic        host1_ren;
  logic [31:0] host1_data_read;
  logic        host1_ready;

  logic [31:0] bus_address;
  logic [31:0] bus_data_write;
  logic [3:0]  bus_write_mask;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_data_read;
  logic        bus_ready;

  logic [1:0]  grant;
  logic        timeout_err;
  logic        timeout_src;
  logic        err_clear;

  // Arbiter side
  modport slave (
    input  host0_address, host0_data_write, host0_write_mask, host0_wen, host0_ren,
    output host0_data_read, host0_ready,
    input  host1_address, host1_data_write, host1_write_mask, host1_wen, host1_ren,
    output host1_data_read, host1_ready,
    output bus_address, bus_data_write, bus_write_mask, bus_wen, bus_ren,
    input  bus_data_read, bus_ready,
    output grant, timeout_err, timeout_src,
    input  err_clear
  );

  // Environment side: hosts, device and error management
  modport master (
    output host0_address, host0_data_write, host0_write_mask, host0_wen, host0_ren,
    input  host0_data_read, host0_ready,
    output host1_address, host1_data_write, host1_write_mask, host1_wen, host1_ren,
    input  host1_data_read, host1_ready,
    input  bus_address, bus_data_write, bus_write_mask, bus_wen, bus_ren,
    output bus_data_read, bus_ready,
    input  grant, timeout_err, timeout_src,
    output err_clear
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_2
// Brief    : Two-host round-robin bus arbiter with per-transaction watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_2 #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_2_if.slave arb
);

  localparam int c_CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = {c_CNT_W{1'b1}};
  localparam logic               c_WD_EN   = (TIMEOUT != 0);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_BUSY = 1'b1;

  logic [0:0]         r_state;
  logic [1:0]         r_grant;
  logic               r_owner;
  logic               r_last_owner;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_timeout_err;
  logic               r_timeout_src;

  logic        w_busy;
  logic        w_req0;
  logic        w_req1;
  logic        w_own_wen;
  logic        w_own_ren;
  logic        w_own_req;
  logic        w_done_ok;
  logic        w_expire;
  logic        w_complete;
  logic        w_pick;
  logic [31:0] w_cpl_data;

  always_comb begin
    w_busy     = (r_state == c_BUSY);
    w_req0     = arb.host0_wen | arb.host0_ren;
    w_req1     = arb.host1_wen | arb.host1_ren;
    w_own_wen  = r_owner ? arb.host1_wen : arb.host0_wen;
    w_own_ren  = r_owner ? arb.host1_ren : arb.host0_ren;
    w_own_req  = w_own_wen | w_own_ren;
    // A real device completion wins over a same-cycle watchdog expiry
    w_done_ok  = w_busy & arb.bus_ready;
    w_expire   = w_busy & ~arb.bus_ready & c_WD_EN & (r_cnt == c_TIMEOUT);
    w_complete = w_done_ok | w_expire;
    w_pick     = (w_req0 & w_req1) ? ~r_last_owner : w_req1;
    w_cpl_data = w_done_ok ? arb.bus_data_read : ERR_DATA;
  end

  assign arb.bus_address    = w_busy ? (r_owner ? arb.host1_address    : arb.host0_address)    : 32'h0;
  assign arb.bus_data_write = w_busy ? (r_owner ? arb.host1_data_write : arb.host0_data_write) : 32'h0;
  assign arb.bus_write_mask = w_busy ? (r_owner ? arb.host1_write_mask : arb.host0_write_mask) : 4'h0;
  assign arb.bus_wen        = w_busy & ~w_expire & w_own_wen;
  assign arb.bus_ren        = w_busy & ~w_expire & w_own_ren;

  assign arb.host0_ready     = w_complete & ~r_owner;
  assign arb.host1_ready     = w_complete & r_owner;
  assign arb.host0_data_read = (w_complete & ~r_owner) ? w_cpl_data : 32'h0;
  assign arb.host1_data_read = (w_complete & r_owner)  ? w_cpl_data : 32'h0;

  assign arb.grant       = r_grant;
  assign arb.timeout_err = r_timeout_err;
  assign arb.timeout_src = r_timeout_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_grant      <= 2'b00;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_req0 | w_req1) begin
            r_state <= c_BUSY;
            r_owner <= w_pick;
            r_grant <= w_pick ? 2'b10 : 2'b01;
            r_cnt   <= '0;
          end
        end
        default: begin
          if (w_complete) begin
            r_state      <= c_IDLE;
            r_grant      <= 2'b00;
            r_last_owner <= r_owner;
          end else if (!w_own_req) begin
            // Abandoned transaction: fairness history is left untouched
            r_state <= c_IDLE;
            r_grant <= 2'b00;
          end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
      r_timeout_src <= 1'b0;
    end else if (w_expire) begin
      r_timeout_err <= 1'b1;
      r_timeout_src <= r_owner;
    end else if (arb.err_clear) begin
      r_timeout_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter_2.md
# bus_arbiter_2

Two-host round-robin arbiter that shares the single SoC bus (the host side of `bus_hub_2`) between the CPU core and a second bus master such as a DMA or debug engine. It grants one host at a time and holds the grant for a whole transaction. It forwards that host's request downstream and routes the completion back. A per-transaction watchdog terminates transactions the device side never completes, so neither host can hang the bus.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum BUSY cycles before forced completion; 0 disables the watchdog.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on a timed-out transaction.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `host0_address` / `host1_address` in 32: request address.
- `host0_data_write` / `host1_data_write` in 32: write data.
- `host0_write_mask` / `host1_write_mask` in 4: byte write mask.
- `host0_wen` / `host1_wen` in 1: write strobe, held until ready.
- `host0_ren` / `host1_ren` in 1: read strobe, held until ready.
- `host0_data_read` / `host1_data_read` out 32: read data, valid when ready.
- `host0_ready` / `host1_ready` out 1: one-cycle completion pulse.
- `bus_address` out 32, `bus_data_write` out 32, `bus_write_mask` out 4, `bus_wen` out 1, `bus_ren` out 1: downstream request.
- `bus_data_read` in 32, `bus_ready` in 1: downstream completion.
- `grant` out 2: one-hot current owner; 0 when idle.
- `timeout_err` out 1: sticky, set on any watchdog expiry.
- `timeout_src` out 1: host index of the most recent timeout.
- `err_clear` in 1: synchronous clear of `timeout_err`.

## Operation
- **Request definition.** A host "requests" when its `wen | ren` is high. The protocol requires address, data, mask and strobes to be held stable until that host's `ready` pulse.
- **States.**
  - IDLE: `grant` = 0. The arbiter picks an owner from the current requests:
    - only one host requests → that host;
    - both request → the host that is not `last_owner`.
    - The chosen `grant` and `owner` are registered, and the arbiter goes to BUSY.
  - BUSY: downstream `bus_*` outputs equal the owner's inputs verbatim. A simultaneous `wen` and `ren` is passed through unchanged.
    - `bus_ready`=1 → owner's `ready`=1 and owner's `data_read`=`bus_data_read` in the same cycle. `last_owner`←owner; next state IDLE.
    - Watchdog counter reaches `TIMEOUT` with `TIMEOUT`≠0 → in that cycle `bus_wen`/`bus_ren` are forced 0. Owner's `ready`=1 and `data_read`=`ERR_DATA`. `timeout_err`←1, `timeout_src`←owner, `last_owner`←owner; next state IDLE.
    - Owner drops both strobes without ready (abandon) → next state IDLE, no `ready`, `last_owner` unchanged.
- **Outside completion.** The non-owner and all hosts in IDLE see `ready`=0 and `data_read`=0. A `bus_ready` arriving in IDLE is ignored.
- **Watchdog counter.** Clears on entry to BUSY and increments once per BUSY cycle. Width is `$clog2(TIMEOUT+1)`, minimum 1; it saturates and never wraps.
- **Error flag.** `err_clear` has priority below a same-cycle timeout set, so the flag stays 1.
- **Downstream outputs outside BUSY.** All `bus_*` outputs are 0.

## Timing
- **Reset values.**
  - state IDLE, `grant`=0, `last_owner`=1 (host0 wins first tie).
  - counter 0, `timeout_err`=0, `timeout_src`=0.
  - all `bus_*` outputs 0, all host `ready` 0 and `data_read` 0.
- **Grant latency.** A request first seen in IDLE at cycle N gives `grant` and the `bus_*` strobe at N+1.
- **Completion.** Host `ready` is combinational from `bus_ready`, with zero added latency.
- **Back-to-back.** Completion at N → IDLE at N+1 → next grant at N+2. Minimum transaction spacing is therefore one idle cycle.
- **Timeout timing.** With `TIMEOUT`=T, a grant at N with no `bus_ready` gives forced `ready` at N+T.
- **Reset mid-transaction.** Reset returns immediately to IDLE with all outputs 0. An in-flight downstream access is dropped.

## Test plan
- **Single host read.** host0 `ren`, address 0x100; the device returns 0x12345678 three cycles after its strobe. Required: `grant`=01 one cycle after the request, and host0 `ready` with data 0x12345678 in the same cycle as `bus_ready`.
- **Fairness.** Both hosts request continuously with single-cycle device completion. Required: grants alternate 01, 10, 01, 10, starting with host0, with one IDLE cycle between grants.
- **Write pass-through.** host1 write, address 0x2000_0004, data 0xA5A5A5A5, mask 4'b0011, while host0 is idle. Required: identical values on `bus_*`, and host0 `ready` stays 0 throughout.
- **Timeout.** `TIMEOUT`=4, host1 reads and the device never answers. Required: host1 `ready` with 0xDEADBEEF exactly 4 cycles after grant, `timeout_err`=1, `timeout_src`=1, `bus_ren`=0 in the expiry cycle. A subsequent `err_clear` pulse clears the flag.
- **Reset and abandon.** Assert `rst` while BUSY, then check all outputs are 0 and host0 wins the next tie. Separately, drop the strobe mid-BUSY and check return to IDLE with no `ready`.
